sub_8bit_serial: RTL

Bit-serial 8-bit subtractor computing `diff = a - b` with borrow-out, one bit per clock, LSB first. It is the arithmetic inverse of the team's combinational 8-bit adder. Together they form an add/subtract pair that benches can cross-check: `a == add(diff, b)` modulo 2^8, with `bout` matching the adder carry semantics inverted. It trades area for latency, using one full-subtractor cell, two shift registers and a small FSM behind a start/done handshake.

---
 rtl/sub_8bit_serial_if.sv | 32 +++
 rtl/sub_8bit_serial.sv | 119 +++++++++++
 2 files changed

// File: rtl/sub_8bit_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : sub_8bit_serial_if
//  Description : Request/result bundle for the bit-serial subtractor.
//                master : drives start/a/b, observes busy/done/diff/bout
//                slave  : the subtractor side of the same signals
//  Ports       : start, a[WIDTH], b[WIDTH]     (master -> slave)
//                busy, done, diff[WIDTH], bout (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sub_8bit_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface : sub_8bit_serial_if
`default_nettype wire

// File: rtl/sub_8bit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : sub_8bit_serial
//  Description : Bit-serial subtractor, diff = a - b (mod 2^WIDTH) with
//                borrow-out, one bit per clock, LSB first. One full-
//                subtractor cell, two operand shift registers, a result
//                accumulator and an IDLE/SHIFT/DONE controller.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus_if - slave side of sub_8bit_serial_if
//                         (start/a/b in, busy/done/diff/bout out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_8bit_serial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sub_8bit_serial_if.slave   bus_if
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] acc_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  // Full-subtractor cell on the current LSBs
  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    bit_d = ra_q[0] ^ rb_q[0] ^ br_q;
    br_d  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    // New bit enters at the MSB so that after WIDTH shifts the LSB-first
    // stream sits in natural bit order.
    acc_d = {bit_d, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus_if.start) begin
            ra_q    <= bus_if.a;
            rb_q    <= bus_if.b;
            acc_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          ra_q  <= ra_q >> 1;
          rb_q  <= rb_q >> 1;
          br_q  <= br_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            // Publish on the same edge as the last shift so the
            // visible result never holds a partial value.
            diff_q  <= acc_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;
  assign bus_if.diff = diff_q;
  assign bus_if.bout = bout_q;

endmodule : sub_8bit_serial
`default_nettype wire
